pipe_stage_reg: RTL



---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_stage_reg_if.sv | 20 ++
 rtl/sat_counter.sv | 17 +
 rtl/pipe_stage_reg.sv | 80 ++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, control-field layout and the all-zero control word for pipeline stages.
package pipe_pkg;
    localparam int CTRL_W_DEF = 9;
    localparam int DATA_W_DEF = 165;
    localparam int ALU_OP_LSB = 0;
    localparam int ALU_OP_W   = 6;
    localparam int WR_REG_BIT = 6;
    localparam int RD_MEM_BIT = 7;
    localparam int WR_MEM_BIT = 8;
    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream and downstream valid/ready bus of one pipeline stage.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    modport master (output in_valid, in_ctrl, in_data, out_ready,
                    input  in_ready, out_valid, out_ctrl, out_data);
    modport slave  (input  in_valid, in_ctrl, in_data, out_ready,
                    output in_ready, out_valid, out_ctrl, out_data);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    assign cnt_o = cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready stage register with flush, bubble injection and bubble counter.
// Define PIPE_STAGE_SKID_EN to add a 1-entry skid buffer that decouples in_ready from out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             bubble_i,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] bubble_cnt
);
    localparam logic [CTRL_W-1:0] NOP = CTRL_W'(CTRL_NOP);
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              free, load, inc;
    assign free = !valid_q || bus.out_ready;
    assign load = bus.in_valid && bus.in_ready;
`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    assign bus.in_ready = !skid_valid_q && !flush_i && !bubble_i;
    assign inc          = bubble_i && !flush_i && !skid_valid_q && free;
    // A free main slot refills from skid first, otherwise from the input.
    always_comb begin
        valid_d      = !flush_i && (free ? (skid_valid_q || load) : 1'b1);
        ctrl_d       = flush_i ? NOP : !free ? ctrl_q : skid_valid_q ? skid_ctrl_q : load ? bus.in_ctrl : NOP;
        data_d       = (flush_i || !free) ? data_q : skid_valid_q ? skid_data_q : load ? bus.in_data : data_q;
        skid_valid_d = !flush_i && !free && (skid_valid_q || load);
        skid_ctrl_d  = !skid_valid_d ? NOP : skid_valid_q ? skid_ctrl_q : bus.in_ctrl;
        skid_data_d  = (load && !free) ? bus.in_data : skid_data_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign bus.in_ready = !flush_i && !bubble_i && free;
    assign inc          = bubble_i && !flush_i && free;
    // in_ready already excludes flush and bubble, so a load never races them.
    always_comb begin
        valid_d = load || (valid_q && !bus.out_ready && !flush_i);
        ctrl_d  = load ? bus.in_ctrl : valid_d ? ctrl_q : NOP;
        data_d  = load ? bus.in_data : data_q;
    end
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end
    assign bus.out_valid = valid_q;
    assign bus.out_ctrl  = ctrl_q;
    assign bus.out_data  = data_q;
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (inc),
        .cnt_o (bubble_cnt)
    );
endmodule
